// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter unit:
// next-PC source select and alignment constants.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JMP,
        SEL_RET,
        SEL_EXC
    } pc_sel_e;

    localparam int unsigned PC_STEP    = 4;
    localparam int unsigned ALIGN_MASK = 3;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push while full overwrites the oldest
// entry; the occupancy count saturates at DEPTH.
module pc_ras
    import pc_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW:0]   CNT_ONE   = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_DEPTH = (PW + 1)'(DEPTH);

    logic [AW-1:0] mem_q [DEPTH];
    logic [AW-1:0] mem_d [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [PW-1:0] top_idx;

    // ptr_q is the next free slot; when full it also points at the oldest entry.
    assign top_idx = ptr_q - PTR_ONE;
    assign top     = mem_q[top_idx];
    assign full    = (count_q == CNT_DEPTH);
    assign empty   = (count_q == '0);

    always_comb begin
        mem_d   = mem_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PTR_ONE;
            if (!full) begin
                count_d = count_q + CNT_ONE;
            end
        end else if (pop && !empty) begin
            ptr_d   = ptr_q - PTR_ONE;
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: prioritised next-PC selection, I/O stall with
// insert override, return-address stack and registered source-line index.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int            AW           = 32,
    parameter logic [AW-1:0] RESET_VECTOR = '0,
    parameter logic [AW-1:0] EXC_VECTOR   = AW'(32'h80),
    parameter int            RAS_DEPTH    = 4,
    parameter int            LINE_OFFSET  = 2
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          input_flag,
    input  logic          output_flag,
    input  logic          insert,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target,
    input  logic          jump,
    input  logic          call,
    input  logic [AW-1:0] jump_target,
    input  logic          ret,
    input  logic          exception,
    output logic [AW-1:0] addressOut,
    output logic [31:0]   linha,
    output logic          ras_overflow,
    output logic          ras_underflow,
    output logic          misaligned
);

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return a & ~(AW'(ALIGN_MASK));
    endfunction

    function automatic logic [31:0] line_of(input logic [AW-1:0] pc);
        logic [AW-1:0] word;
        word = pc >> 2;
        return 32'(word) + 32'(LINE_OFFSET);
    endfunction

    logic [AW-1:0] pc_q, pc_d;
    logic [31:0]   linha_q, linha_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          mis_q, mis_d;

    logic          adv;
    logic          hold;
    pc_sel_e       sel;
    logic          ras_push;
    logic          ras_pop;
    logic          ras_full;
    logic          ras_empty;
    logic [AW-1:0] ras_top;
    logic [AW-1:0] pc_seq;

    assign adv    = (!input_flag && !output_flag) || insert;
    assign pc_seq = align(pc_q + AW'(PC_STEP));

    // Source selection; exception bypasses the stall, everything else needs adv.
    always_comb begin
        sel      = SEL_SEQ;
        hold     = 1'b0;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        mis_d    = 1'b0;
        if (exception) begin
            sel = SEL_EXC;
        end else if (!adv) begin
            hold = 1'b1;
        end else if (call) begin
            sel      = SEL_JMP;
            ras_push = 1'b1;
            ovf_d    = ras_full;
            mis_d    = |jump_target[1:0];
        end else if (jump) begin
            sel   = SEL_JMP;
            mis_d = |jump_target[1:0];
        end else if (ret) begin
            if (ras_empty) begin
                unf_d = 1'b1;
            end else begin
                sel     = SEL_RET;
                ras_pop = 1'b1;
            end
        end else if (branch_taken) begin
            sel   = SEL_BR;
            mis_d = |branch_target[1:0];
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (!hold) begin
            unique case (sel)
                SEL_SEQ: pc_d = pc_seq;
                SEL_BR:  pc_d = align(branch_target);
                SEL_JMP: pc_d = align(jump_target);
                SEL_RET: pc_d = align(ras_top);
                SEL_EXC: pc_d = EXC_VECTOR;
                default: pc_d = pc_seq;
            endcase
        end
        linha_d = line_of(pc_d);
    end

    pc_ras #(
        .AW    (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (CLK),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_seq),
        .top       (ras_top),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            pc_q    <= RESET_VECTOR;
            linha_q <= line_of(RESET_VECTOR);
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            linha_q <= linha_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            mis_q   <= mis_d;
        end
    end

    assign addressOut    = pc_q;
    assign linha         = linha_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
    assign misaligned    = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table followed by random stimulus
// checked against a queue-based model of the PC and return-address stack.
module tb_pc_sequencer;

    localparam int RAS_DEPTH = 4;
    localparam int EW        = 32 + 32 + 3;

    localparam logic [8:0] C_RST  = 9'b1_0000_0000;
    localparam logic [8:0] C_INF  = 9'b0_1000_0000;
    localparam logic [8:0] C_OUTF = 9'b0_0100_0000;
    localparam logic [8:0] C_INS  = 9'b0_0010_0000;
    localparam logic [8:0] C_BR   = 9'b0_0001_0000;
    localparam logic [8:0] C_JMP  = 9'b0_0000_1000;
    localparam logic [8:0] C_CALL = 9'b0_0000_0100;
    localparam logic [8:0] C_RET  = 9'b0_0000_0010;
    localparam logic [8:0] C_EXC  = 9'b0_0000_0001;
    localparam logic [8:0] C_IDLE = 9'b0;

    typedef struct {
        logic [8:0]  ctl;
        logic [31:0] bt;
        logic [31:0] jt;
        logic [31:0] e_pc;
        logic [31:0] e_linha;
        logic [2:0]  e_pulse;
    } vec_t;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        input_flag = 1'b0;
    logic        output_flag = 1'b0;
    logic        insert = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic        call = 1'b0;
    logic [31:0] jump_target = '0;
    logic        ret = 1'b0;
    logic        exception = 1'b0;
    logic [31:0] addressOut;
    logic [31:0] linha;
    logic        ras_overflow;
    logic        ras_underflow;
    logic        misaligned;

    int errors = 0;
    int checks = 0;
    logic [EW-1:0] exp_q[$];
    vec_t vecs[$];

    logic [31:0] m_pc;
    logic [31:0] m_ras[$];

    pc_sequencer #(
        .AW           (32),
        .RESET_VECTOR (32'h0),
        .EXC_VECTOR   (32'h80),
        .RAS_DEPTH    (RAS_DEPTH),
        .LINE_OFFSET  (2)
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .input_flag    (input_flag),
        .output_flag   (output_flag),
        .insert        (insert),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .call          (call),
        .jump_target   (jump_target),
        .ret           (ret),
        .exception     (exception),
        .addressOut    (addressOut),
        .linha         (linha),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow),
        .misaligned    (misaligned)
    );

    // Clock and watchdog
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void add(input logic [8:0] ctl, input logic [31:0] bt,
                                input logic [31:0] jt, input logic [31:0] e_pc,
                                input logic [31:0] e_linha, input logic [2:0] e_pulse);
        vec_t v;
        v.ctl = ctl; v.bt = bt; v.jt = jt;
        v.e_pc = e_pc; v.e_linha = e_linha; v.e_pulse = e_pulse;
        vecs.push_back(v);
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Driver: apply one cycle of inputs, queue its expectation, check after the edge.
    task automatic run_vec(input vec_t v, input string nm);
        logic [EW-1:0] e;
        reset         = v.ctl[8];
        input_flag    = v.ctl[7];
        output_flag   = v.ctl[6];
        insert        = v.ctl[5];
        branch_taken  = v.ctl[4];
        jump          = v.ctl[3];
        call          = v.ctl[2];
        ret           = v.ctl[1];
        exception     = v.ctl[0];
        branch_target = v.bt;
        jump_target   = v.jt;
        exp_q.push_back({v.e_pc, v.e_linha, v.e_pulse});
        @(posedge CLK);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_queue: got empty expected queue", nm);
        end else begin
            e = exp_q.pop_front();
            cmp({nm, "_pc"},    addressOut, e[EW-1:35]);
            cmp({nm, "_linha"}, linha,      e[34:3]);
            cmp({nm, "_ovf"},   {31'b0, ras_overflow},  {31'b0, e[2]});
            cmp({nm, "_unf"},   {31'b0, ras_underflow}, {31'b0, e[1]});
            cmp({nm, "_mis"},   {31'b0, misaligned},    {31'b0, e[0]});
        end
    endtask

    // Reference model: next PC from the priority rules, RAS as a bounded queue.
    task automatic model_step(inout vec_t v);
        logic adv;
        logic ovf, unf, mis;
        ovf = 0; unf = 0; mis = 0;
        adv = (!v.ctl[7] && !v.ctl[6]) || v.ctl[5];
        if (v.ctl[8]) begin
            m_pc = 32'h0;
            m_ras.delete();
        end else if (v.ctl[0]) begin
            m_pc = 32'h80;
        end else if (adv) begin
            if (v.ctl[2]) begin
                if (m_ras.size() == RAS_DEPTH) begin
                    ovf = 1;
                    void'(m_ras.pop_front());
                end
                m_ras.push_back(m_pc + 32'd4);
                mis  = (v.jt % 4) != 0;
                m_pc = v.jt - (v.jt % 4);
            end else if (v.ctl[3]) begin
                mis  = (v.jt % 4) != 0;
                m_pc = v.jt - (v.jt % 4);
            end else if (v.ctl[1]) begin
                if (m_ras.size() == 0) begin
                    unf  = 1;
                    m_pc = m_pc + 32'd4;
                end else begin
                    m_pc = m_ras.pop_back();
                end
            end else if (v.ctl[4]) begin
                mis  = (v.bt % 4) != 0;
                m_pc = v.bt - (v.bt % 4);
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
        v.e_pc    = m_pc;
        v.e_linha = (m_pc / 4) + 32'd2;
        v.e_pulse = {ovf, unf, mis};
    endtask

    initial begin
        vec_t r;
        int   p;

        // Reset, then free-running sequential fetch
        add(C_RST,  0, 0, 32'h0,  32'h2, 3'b000);
        add(C_RST,  0, 0, 32'h0,  32'h2, 3'b000);
        add(C_IDLE, 0, 0, 32'h4,  32'h3, 3'b000);
        add(C_IDLE, 0, 0, 32'h8,  32'h4, 3'b000);
        add(C_IDLE, 0, 0, 32'hC,  32'h5, 3'b000);
        // Stall with insert override
        add(C_INF,         0, 0, 32'hC,  32'h5, 3'b000);
        add(C_INF | C_INS, 0, 0, 32'h10, 32'h6, 3'b000);
        add(C_INF,         0, 0, 32'h10, 32'h6, 3'b000);
        add(C_IDLE, 0, 0, 32'h14, 32'h7, 3'b000);
        add(C_IDLE, 0, 0, 32'h18, 32'h8, 3'b000);
        add(C_IDLE, 0, 0, 32'h1C, 32'h9, 3'b000);
        add(C_IDLE, 0, 0, 32'h20, 32'hA, 3'b000);
        // Call / return / underflow
        add(C_CALL, 0, 32'h100, 32'h100, 32'h42, 3'b000);
        add(C_RET,  0, 0,       32'h24,  32'hB,  3'b000);
        add(C_RET,  0, 0,       32'h28,  32'hC,  3'b010);
        add(C_IDLE, 0, 0,       32'h2C,  32'hD,  3'b000);
        // Five calls overflow a 4-deep stack
        add(C_CALL, 0, 32'h200, 32'h200, 32'h82,  3'b000);
        add(C_CALL, 0, 32'h300, 32'h300, 32'hC2,  3'b000);
        add(C_CALL, 0, 32'h400, 32'h400, 32'h102, 3'b000);
        add(C_CALL, 0, 32'h500, 32'h500, 32'h142, 3'b000);
        add(C_CALL, 0, 32'h600, 32'h600, 32'h182, 3'b100);
        add(C_RET,  0, 0, 32'h504, 32'h143, 3'b000);
        add(C_RET,  0, 0, 32'h404, 32'h103, 3'b000);
        add(C_RET,  0, 0, 32'h304, 32'hC3,  3'b000);
        add(C_RET,  0, 0, 32'h204, 32'h83,  3'b000);
        add(C_RET,  0, 0, 32'h208, 32'h84,  3'b010);
        // Exception beats everything, including the stall
        add(C_BR | C_JMP | C_EXC | C_OUTF, 32'h40, 32'h80, 32'h80, 32'h22, 3'b000);
        // Misaligned branch, then wrap of PC+4
        add(C_BR,   32'h33, 0, 32'h30, 32'hE, 3'b001);
        add(C_JMP,  0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h4000_0001, 3'b000);
        add(C_IDLE, 0, 0, 32'h0, 32'h2, 3'b000);
        // Reset overrides a call and clears the stack
        add(C_RST | C_CALL, 0, 32'h500, 32'h0, 32'h2, 3'b000);
        add(C_RET,  0, 0, 32'h4, 32'h3, 3'b010);
        // Stalled branch holds; stalled exception still loads
        add(C_OUTF | C_BR, 32'h700, 0, 32'h4,  32'h3,  3'b000);
        add(C_INF | C_EXC, 0, 0,       32'h80, 32'h22, 3'b000);
        // Misaligned call via insert, call beats ret, exception leaves RAS alone
        add(C_INF | C_OUTF | C_INS | C_CALL, 0, 32'h103, 32'h100, 32'h42, 3'b001);
        add(C_RET | C_CALL, 0, 32'h200, 32'h200, 32'h82, 3'b000);
        add(C_RET,  0, 0, 32'h104, 32'h43, 3'b000);
        add(C_RET,  0, 0, 32'h84,  32'h23, 3'b000);
        add(C_RET,  0, 0, 32'h88,  32'h24, 3'b010);
        add(C_CALL, 0, 32'h300, 32'h300, 32'hC2, 3'b000);
        add(C_EXC,  0, 0, 32'h80, 32'h22, 3'b000);
        add(C_RET,  0, 0, 32'h8C, 32'h25, 3'b000);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Random phase, starting from a model-tracked reset
        r.ctl = C_RST; r.bt = '0; r.jt = '0;
        model_step(r);
        run_vec(r, "rnd_reset");
        for (int i = 0; i < 600; i++) begin
            r.ctl = '0;
            r.ctl[8] = ($urandom_range(0, 99) < 2);
            r.ctl[7] = ($urandom_range(0, 99) < 20);
            r.ctl[6] = ($urandom_range(0, 99) < 15);
            r.ctl[5] = ($urandom_range(0, 99) < 20);
            r.ctl[0] = ($urandom_range(0, 99) < 5);
            p = int'($urandom_range(0, 99));
            if (p < 25)      r.ctl[2] = 1'b1;
            else if (p < 50) r.ctl[1] = 1'b1;
            else if (p < 60) r.ctl[3] = 1'b1;
            else if (p < 75) r.ctl[4] = 1'b1;
            if ($urandom_range(0, 3) == 0) r.ctl[1] = 1'b1;
            if ($urandom_range(0, 3) == 0) r.ctl[4] = 1'b1;
            r.bt = $urandom();
            r.jt = $urandom();
            if ($urandom_range(0, 9) == 0) r.jt = 32'hFFFF_FFFC;
            model_step(r);
            run_vec(r, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
